mem_stage_cached: RTL
=====================

Name: mem_stage_cached

Overview:
- Parametrised MEM-stage successor with an integrated direct-mapped, write-through, one-word-per-line cache.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads and misaligned-access detection.
- Talks to backing memory through a variable-latency req/ready handshake and raises stall to freeze the pipeline during misses and writes.
- Sits between EX/MEM and MEM/WB pipeline registers; includes saturating hit and miss counters.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2; IDX_W = log2(NUM_LINES).
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM-stage instruction is a load or store.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- req_signed  in  1  sign-extend byte/halfword loads when 1.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data; the low bytes hold the datum.
- stall  out  1  pipeline must hold all req_* inputs stable while high.
- rdata  out  32  load result, extended to 32 bits.
- rdata_valid  out  1  rdata is valid this cycle.
- misaligned  out  1  current request is misaligned.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address, with [1:0] = 00.
- mem_be  out  4  byte enables; bit 3 = byte 0.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  memory completes the request this cycle.
- hit_count  out  CNT_W  saturating load-hit count.
- miss_count  out  CNT_W  saturating load-miss count.

Behaviour:
- Byte order is big-endian: byte 0 = bits [31:24], byte 3 = bits [7:0]. Byte lane = req_addr[1:0].
- Address split: index = req_addr[IDX_W+1:2]; tag = req_addr[31:IDX_W+2].
- Per-line state is a valid bit, tag and 32-bit data word. Only valid bits are reset; tag and data arrays are not.
- Misaligned conditions: halfword with addr[0]=1, or word with addr[1:0]≠00.
- On a misaligned request: misaligned=1 combinationally, stall=0, rdata_valid=0, no memory access, no cache change, counters unchanged.
- FSM states: IDLE, FILL, WRITE.
- IDLE, load hit (valid and tag match):
  - rdata_valid=1 in the same cycle; stall=0; hit_count increments.
  - Extraction: byte takes the lane byte; halfword takes lanes {0,1} when addr[1]=0, else {2,3}.
  - Extension: sign-extend if req_signed, otherwise zero-extend.
- IDLE, load miss: stall=1 combinationally; next state FILL; miss_count increments once, on the IDLE→FILL edge.
- FILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr = {req_addr[31:2],2'b00}, mem_be=1111, stall=1.
  - On mem_ready: write mem_rdata into the line, set valid, load the tag, go to IDLE.
  - The following cycle hits; total miss latency = memory latency + 2 cycles.
- IDLE, store: stall=1; next state WRITE. A store counts as neither a hit nor a miss.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, stall=1.
  - mem_be by size: byte → one-hot lane; halfword → 1100 or 0011; word → 1111.
  - mem_wdata replicates the datum into the selected lanes; other lanes are 0.
  - On mem_ready: if the line hits, merge the enabled bytes into the line (write-through with update). On a write miss, leave the line unchanged (no-write-allocate). Go to IDLE with stall=0 in that same cycle.
- The FSM moves only through these transitions; mem_ready seen in IDLE is ignored.
- req_valid=0 in IDLE: no action, stall=0.
- Counters saturate at all-ones and never wrap.
- rdata_valid is only ever high in IDLE; rdata=0 whenever rdata_valid=0.
- Reset values: state=IDLE, all valid bits=0, counters=0, mem_req=0, mem_we=0, stall=0, rdata_valid=0.
- Reset asserted during FILL or WRITE: return to IDLE immediately (asynchronous), mem_req drops, fill data is discarded.

Test Plan:
- Reset, then load word at 0x40, memory returns 0x11223344 after 3 cycles → miss_count=1, stall for 5 cycles, line filled; repeat load → rdata=0x11223344 with no stall, hit_count=1.
- After line 0x40 is filled, signed byte load at 0x43 → rdata=0x00000044. With the line holding 0xFF000000, signed byte load at 0x40 → 0xFFFFFF80? No: byte 0xFF → rdata=0xFFFFFFFF; unsigned → 0x000000FF.
- Store byte 0xAB to 0x41 with line 0x40 cached → mem_be=0100, mem_wdata=0x00AB0000, mem_we=1; after mem_ready, load word at 0x40 hits with 0x11AB3344.
- Halfword load at 0x41 → misaligned=1, stall=0, mem_req never asserted, counters unchanged.
- Load at 0x80 (same index as 0x40 when NUM_LINES=16) → miss, line replaced; reload at 0x40 → miss again, miss_count increments.
- Assert rst_b low during FILL → mem_req falls in the same cycle; after reset, load 0x40 misses (valid bit cleared).

Source files
------------

// File: rtl/mem_stage_cached.sv
// MEM stage with a direct-mapped, write-through, no-write-allocate, one-word-per-line cache.
// Big-endian byte lanes: lane 0 = bits [31:24]. Loads hit in the same cycle; misses fill
// from backing memory through a req/ready handshake while stall freezes the pipeline.
module mem_stage_cached #(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic [CNT_W-1:0]     hit_q, hit_d, miss_q, miss_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_rdata;
    logic             hit;
    logic             is_byte, is_half, is_word;
    logic             misalign_c;
    logic [3:0]       be;
    logic [31:0]      be_mask;
    logic [31:0]      store_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_ext;
    logic             line_we;
    logic [31:0]      line_wdata;

    assign idx        = req_addr[IDX_W+1:2];
    assign tag        = req_addr[31:IDX_W+2];
    assign line_rdata = data_q[idx];
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);

    assign is_byte    = (req_size == 2'b00);
    assign is_half    = (req_size == 2'b01);
    assign is_word    = req_size[1];
    assign misalign_c = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    assign misaligned = req_valid && misalign_c;

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // Store byte enables and the datum replicated across every lane it could occupy.
    always_comb begin
        be         = 4'b1111;
        store_word = req_wdata;
        if (is_byte) begin
            be         = 4'b1000 >> req_addr[1:0];
            store_word = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be         = req_addr[1] ? 4'b0011 : 4'b1100;
            store_word = {2{req_wdata[15:0]}};
        end
        be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // Load lane extraction and sign/zero extension from the addressed line.
    always_comb begin
        ld_byte = 8'h00;
        unique case (req_addr[1:0])
            2'b00: ld_byte = line_rdata[31:24];
            2'b01: ld_byte = line_rdata[23:16];
            2'b10: ld_byte = line_rdata[15:8];
            2'b11: ld_byte = line_rdata[7:0];
            default: ld_byte = 8'h00;
        endcase
        ld_half = req_addr[1] ? line_rdata[15:0] : line_rdata[31:16];
        if (is_byte) begin
            load_ext = {{24{req_signed & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_ext = {{16{req_signed & ld_half[15]}}, ld_half};
        end else begin
            load_ext = line_rdata;
        end
    end

    // Next-state, cache update and output decode.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        stall       = 1'b0;
        rdata       = 32'h0;
        rdata_valid = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {req_addr[31:2], 2'b00};
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0;
        line_we     = 1'b0;
        line_wdata  = line_rdata;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !misalign_c) begin
                    if (req_write) begin
                        stall   = 1'b1;
                        state_d = StWrite;
                    end else if (hit) begin
                        rdata_valid = 1'b1;
                        rdata       = load_ext;
                        if (hit_q != '1) hit_d = hit_q + CntOne;
                    end else begin
                        stall   = 1'b1;
                        state_d = StFill;
                        if (miss_q != '1) miss_d = miss_q + CntOne;
                    end
                end
            end
            StFill: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                stall   = 1'b1;
                if (mem_ready) begin
                    line_we      = 1'b1;
                    line_wdata   = mem_rdata;
                    valid_d[idx] = 1'b1;
                    state_d      = StIdle;
                end
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = be;
                mem_wdata = store_word & be_mask;
                // Release the pipeline in the completing cycle so the store retires now.
                stall     = !mem_ready;
                if (mem_ready) begin
                    state_d = StIdle;
                    if (hit) begin
                        line_we    = 1'b1;
                        line_wdata = (line_rdata & ~be_mask) | (store_word & be_mask);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, valid bits and counters; async reset returns to idle and invalidates the cache.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            valid_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Tag and data arrays are not reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
        end
    end

endmodule
